edge_event_arbiter: RTL and testbench

//  Multi-channel dual-edge event scheduler. Detects rising and falling edges on
//  NCH async-free input lines and holds one pending event per channel. Shares a

---
 rtl/edge_event_arbiter.sv | 150 +++++++++++++++
 tb/tb_edge_event_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// Dual-edge event scheduler: per-channel edge detection with one pending slot per channel.
// A round-robin arbiter shares a single valid/ready event port between the channels.
module edge_event_arbiter #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] din,
  input  logic [NCH-1:0] en,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [CW-1:0]  evt_ch,
  output logic           evt_rise,
  output logic [NCH-1:0] ovf,
  input  logic [NCH-1:0] ovf_clr
);

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  state_e         state_q, state_d;
  logic [NCH-1:0] s1_q, s2_q;
  logic [1:0]     warm_cnt_q;
  logic           warm;
  logic [NCH-1:0] edge_d, edge_q, edge_rise_q;
  logic [NCH-1:0] pend_q, pend_d, pend_rise_q, pend_rise_d;
  logic [NCH-1:0] ovf_q, ovf_d;
  logic [NCH-1:0] offered_oh, accept_oh;
  logic [CW-1:0]  rr_q, rr_d, ch_q, ch_d;
  logic           rise_q, rise_d;
  logic           found;
  logic [CW-1:0]  sel, cand;

  // warm only after two post-reset samples are held, so static levels at reset make no edge
  assign warm   = (warm_cnt_q == 2'd2);
  assign edge_d = (s1_q ^ s2_q) & en & {NCH{warm}};

  // Input history, warm-up counter and a registered edge stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      warm_cnt_q  <= '0;
      edge_q      <= '0;
      edge_rise_q <= '0;
    end else begin
      s1_q        <= din;
      s2_q        <= s1_q;
      if (!warm) warm_cnt_q <= warm_cnt_q + 2'd1;
      edge_q      <= edge_d;
      edge_rise_q <= s1_q;
    end
  end

  // Decode which channel is currently offered and whether it is being accepted
  always_comb begin
    offered_oh = '0;
    for (int i = 0; i < NCH; i++) begin
      offered_oh[i] = evt_valid && (ch_q == CW'(i));
    end
    accept_oh = offered_oh & {NCH{evt_ready}};
  end

  // Pending slots: keep the oldest edge, flag drops; accept in the same cycle frees the slot
  always_comb begin
    pend_d      = pend_q;
    pend_rise_d = pend_rise_q;
    ovf_d       = ovf_q & ~ovf_clr;
    for (int i = 0; i < NCH; i++) begin
      if (edge_q[i] && en[i]) begin
        if (!pend_q[i] || accept_oh[i]) begin
          pend_d[i]      = 1'b1;
          pend_rise_d[i] = edge_rise_q[i];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end else if (accept_oh[i]) begin
        pend_d[i] = 1'b0;
      end else if (!en[i] && !offered_oh[i]) begin
        // An offer is never retracted, so a disabled channel keeps its slot while offered
        pend_d[i] = 1'b0;
      end
    end
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      cand = CW'((32'(rr_q) + k) % NCH);
      if (!found && pend_q[cand] && en[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Offer FSM next-state: IDLE latches a winner, OFFER holds until the handshake
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rise_d  = rise_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          ch_d    = sel;
          rise_d  = pend_rise_q[sel];
          state_d = StOffer;
        end
      end
      StOffer: begin
        if (evt_ready) begin
          rr_d    = ch_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, pending slots, overflow flags and the offered event registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      pend_rise_q <= '0;
      ovf_q       <= '0;
      rr_q        <= CW'(NCH - 1);
      ch_q        <= '0;
      rise_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_rise_q <= pend_rise_d;
      ovf_q       <= ovf_d;
      rr_q        <= rr_d;
      ch_q        <= ch_d;
      rise_q      <= rise_d;
    end
  end

  assign evt_valid = (state_q == StOffer);
  assign evt_ch    = ch_q;
  assign evt_rise  = rise_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: scoreboard of expected events plus per-scenario checks.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic [3:0] en;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_rise;
  logic [3:0] ovf;
  logic [3:0] ovf_clr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Expected event as {ch[1:0], rise}
  logic [2:0] exp_q[$];
  logic [2:0] mon_exp;

  edge_event_arbiter #(
    .NCH(4),
    .CW (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .en       (en),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_ch   (evt_ch),
    .evt_rise (evt_rise),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted event must match the head of the expected queue
  always @(negedge clk) begin
    if (rst === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got ch=%0d rise=%0d, required no event", evt_ch, evt_rise);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({evt_ch, evt_rise} !== mon_exp) begin
          $display("FAIL sb_event: got ch=%0d rise=%0d, required ch=%0d rise=%0d",
                   evt_ch, evt_rise, mon_exp[2:1], mon_exp[0]);
        end else begin
          pass_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [3:0] d);
    rst       = 1'b0;
    din       = d;
    en        = 4'b1111;
    evt_ready = 1'b0;
    ovf_clr   = 4'b0000;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) tick();
  endtask

  task automatic wait_empty(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_valid(input int ncyc, output int cnt);
    cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (evt_valid === 1'b1) cnt++;
    end
  endtask

  task automatic test_reset();
    int vcnt;
    rst       = 1'b0;
    din       = 4'b1111;
    en        = 4'b1111;
    evt_ready = 1'b0;
    ovf_clr   = 4'b0000;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (evt_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", evt_valid);
    else pass_cnt++;
    total_cnt++;
    if (evt_ch !== 2'd0) $display("FAIL rst_ch: got %0d, required 0", evt_ch);
    else pass_cnt++;
    total_cnt++;
    if (evt_rise !== 1'b0) $display("FAIL rst_rise: got %b, required 0", evt_rise);
    else pass_cnt++;
    total_cnt++;
    if (ovf !== 4'b0000) $display("FAIL rst_ovf: got %b, required 0000", ovf);
    else pass_cnt++;
    tick();
    rst = 1'b1;
    count_valid(10, vcnt);
    total_cnt++;
    if (vcnt !== 0) $display("FAIL static_high_no_event: got %0d valid cycles, required 0", vcnt);
    else pass_cnt++;
  endtask

  task automatic test_single_rise();
    logic [5:0] pat;
    int         vcnt;
    apply_reset(4'b0000);
    evt_ready = 1'b1;
    din[2]    = 1'b1;
    exp_q.push_back({2'd2, 1'b1});
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pat[c] = evt_valid;
    end
    total_cnt++;
    if (pat !== 6'b010000) $display("FAIL rise_latency: got valid pattern %b, required 010000", pat);
    else pass_cnt++;
    total_cnt++;
    if (ovf !== 4'b0000) $display("FAIL rise_ovf: got %b, required 0000", ovf);
    else pass_cnt++;
    count_valid(6, vcnt);
    total_cnt++;
    if (vcnt !== 0) $display("FAIL rise_pend_cleared: got %0d valid cycles, required 0", vcnt);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL rise_drain: got %0d left, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_all_channels();
    int  acc[$];
    bit  gap_ok;
    int  bad_gap;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        apply_reset(4'b0000);
        evt_ready = 1'b1;
        din       = 4'b1111;
      end else begin
        tick();
        din = 4'b0000;
      end
      for (int ch = 0; ch < 4; ch++) exp_q.push_back({ch[1:0], (pass == 0) ? 1'b1 : 1'b0});
      acc.delete();
      for (int c = 0; c < 24; c++) begin
        @(negedge clk);
        if (evt_valid === 1'b1 && evt_ready === 1'b1) acc.push_back(c);
      end
      total_cnt++;
      if (acc.size() !== 4) $display("FAIL all_count_%0d: got %0d events, required 4", pass, acc.size());
      else pass_cnt++;
      gap_ok  = 1'b1;
      bad_gap = 0;
      for (int i = 1; i < acc.size(); i++) begin
        if (acc[i] - acc[i-1] != 2) begin
          gap_ok  = 1'b0;
          bad_gap = acc[i] - acc[i-1];
        end
      end
      total_cnt++;
      if (gap_ok !== 1'b1) $display("FAIL all_spacing_%0d: got gap %0d, required 2", pass, bad_gap);
      else pass_cnt++;
      total_cnt++;
      if (exp_q.size() !== 0) $display("FAIL all_drain_%0d: got %0d left, required 0", pass, exp_q.size());
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    int vcnt;
    apply_reset(4'b0000);
    din[1] = 1'b1;
    tick();
    tick();
    din[1] = 1'b0;
    exp_q.push_back({2'd1, 1'b1});
    repeat (6) @(negedge clk);
    total_cnt++;
    if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd1, 1'b1})
      $display("FAIL ovf_offer_held: got v=%b ch=%0d r=%b, required v=1 ch=1 r=1",
               evt_valid, evt_ch, evt_rise);
    else pass_cnt++;
    total_cnt++;
    if (ovf !== 4'b0010) $display("FAIL ovf_set: got %b, required 0010", ovf);
    else pass_cnt++;
    tick();
    evt_ready = 1'b1;
    @(negedge clk);
    count_valid(8, vcnt);
    total_cnt++;
    if (vcnt !== 0) $display("FAIL ovf_no_fall_event: got %0d valid cycles, required 0", vcnt);
    else pass_cnt++;
    total_cnt++;
    if (ovf !== 4'b0010) $display("FAIL ovf_sticky: got %b, required 0010", ovf);
    else pass_cnt++;
    tick();
    ovf_clr = 4'b0010;
    tick();
    ovf_clr = 4'b0000;
    @(negedge clk);
    total_cnt++;
    if (ovf !== 4'b0000) $display("FAIL ovf_clear: got %b, required 0000", ovf);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL ovf_drain: got %0d left, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_enable();
    int vcnt;
    bit ok;
    apply_reset(4'b0000);
    evt_ready = 1'b1;
    en        = 4'b0111;
    din[3]    = 1'b1;
    repeat (3) tick();
    din[3] = 1'b0;
    repeat (3) tick();
    din[3] = 1'b1;
    count_valid(6, vcnt);
    total_cnt++;
    if (vcnt !== 0) $display("FAIL en_disabled: got %0d valid cycles, required 0", vcnt);
    else pass_cnt++;
    tick();
    en = 4'b1111;
    count_valid(8, vcnt);
    total_cnt++;
    if (vcnt !== 0) $display("FAIL en_static_reenable: got %0d valid cycles, required 0", vcnt);
    else pass_cnt++;
    tick();
    din[3] = 1'b0;
    exp_q.push_back({2'd3, 1'b0});
    wait_empty(12, ok);
    total_cnt++;
    if (ok !== 1'b1) $display("FAIL en_fall_after_enable: got no event, required ch=3 fall");
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_offer();
    bit ok;
    apply_reset(4'b0000);
    din[2] = 1'b1;
    tick();
    tick();
    din[2] = 1'b0;
    repeat (6) @(negedge clk);
    total_cnt++;
    if ({evt_valid, ovf} !== {1'b1, 4'b0100})
      $display("FAIL mid_pre: got v=%b ovf=%b, required v=1 ovf=0100", evt_valid, ovf);
    else pass_cnt++;
    @(posedge clk);
    #3;
    rst = 1'b0;
    din = 4'b0000;
    #1;
    total_cnt++;
    if ({evt_valid, evt_ch, evt_rise, ovf} !== {1'b0, 2'd0, 1'b0, 4'b0000})
      $display("FAIL mid_async_reset: got v=%b ch=%0d r=%b ovf=%b, required all 0",
               evt_valid, evt_ch, evt_rise, ovf);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) tick();
    evt_ready = 1'b1;
    din       = 4'b1111;
    for (int ch = 0; ch < 4; ch++) exp_q.push_back({ch[1:0], 1'b1});
    wait_empty(30, ok);
    total_cnt++;
    if (ok !== 1'b1) $display("FAIL mid_regrant: got %0d events missing, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_all_channels();
    test_overflow();
    test_enable();
    test_reset_mid_offer();
    repeat (2) tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard time limit so a stuck DUT can never hang the run
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, required finish before 200000");
    $fatal(1);
  end

endmodule
